// File: rtl/mem32_master.sv
// mem32_master: single-outstanding command initiator for the 16-entry mem32
// word store. Accepts a read or write from the host, drives the mem32 strobes,
// and returns exactly one response per command with an OK, misaligned or
// timeout status. All outputs come straight from flops.
//
// Handshake: a command transfers on a rising edge where cmd_valid & cmd_ready
// are both 1; a response transfers on a rising edge where rsp_valid & rsp_ready
// are both 1. rsp_valid, rsp_rdata and rsp_code stay stable until that edge,
// and cmd_ready stays low while a command is outstanding.
module mem32_master #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic        Clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [3:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_code,
  output logic [7:0]  err_count,
  output logic        mem_wr,
  output logic        mem_rd,
  output logic [3:0]  mem_add,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_valid,
  output logic [1:0]  dbg_state
);

  localparam int unsigned   CW       = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] RSP_OK       = 2'b00;
  localparam logic [1:0] RSP_MISALIGN = 2'b01;
  localparam logic [1:0] RSP_TIMEOUT  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]    rsp_code_q, rsp_code_d;
  logic [7:0]    err_count_q, err_count_d;
  logic          mem_wr_q, mem_wr_d;
  logic          mem_rd_q, mem_rd_d;
  logic [3:0]    mem_add_q, mem_add_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;

  // Next-state, response capture and registered output decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_code_d  = rsp_code_q;
    err_count_d = err_count_q;
    mem_add_d   = mem_add_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          if (cmd_addr[1:0] != 2'b00) begin
            // Misaligned commands never touch the memory bus.
            state_d     = S_RESP;
            rsp_code_d  = RSP_MISALIGN;
            rsp_rdata_d = 32'd0;
          end else if (cmd_we) begin
            state_d     = S_WR;
            mem_add_d   = cmd_addr;
            mem_wdata_d = cmd_wdata;
          end else begin
            state_d   = S_RD;
            cnt_d     = '0;
            mem_add_d = cmd_addr;
          end
        end
      end
      S_WR: begin
        state_d     = S_RESP;
        rsp_code_d  = RSP_OK;
        rsp_rdata_d = 32'd0;
      end
      S_RD: begin
        // A valid arriving on the last allowed edge still wins over timeout.
        if (mem_valid) begin
          state_d     = S_RESP;
          rsp_code_d  = RSP_OK;
          rsp_rdata_d = mem_rdata;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = S_RESP;
          rsp_code_d  = RSP_TIMEOUT;
          rsp_rdata_d = 32'd0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Count error responses once, on entry to RESP, saturating at 255.
    if ((state_q != S_RESP) && (state_d == S_RESP) && (rsp_code_d != RSP_OK) &&
        (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end

    cmd_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
    mem_wr_d    = (state_d == S_WR);
    mem_rd_d    = (state_d == S_RD);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_code_q  <= RSP_OK;
      err_count_q <= 8'd0;
      mem_wr_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_add_q   <= 4'd0;
      mem_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_code_q  <= rsp_code_d;
      err_count_q <= err_count_d;
      mem_wr_q    <= mem_wr_d;
      mem_rd_q    <= mem_rd_d;
      mem_add_q   <= mem_add_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_code  = rsp_code_q;
  assign err_count = err_count_q;
  assign mem_wr    = mem_wr_q;
  assign mem_rd    = mem_rd_q;
  assign mem_add   = mem_add_q;
  assign mem_wdata = mem_wdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem32_master.sv
// tb_mem32_master: directed and randomized checks of mem32_master against a
// transaction-level model (per-command latency, status and data rules) plus a
// small mem32 stand-in whose response delay is chosen per command.
module tb_mem32_master;

  localparam int TIMEOUT = 8;

  logic        Clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_code;
  logic [7:0]  err_count;
  logic        mem_wr;
  logic        mem_rd;
  logic [3:0]  mem_add;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic [1:0]  dbg_state;

  mem32_master #(.TIMEOUT(TIMEOUT)) dut (
    .Clk       (Clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_code  (rsp_code),
    .err_count (err_count),
    .mem_wr    (mem_wr),
    .mem_rd    (mem_rd),
    .mem_add   (mem_add),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_valid (mem_valid),
    .dbg_state (dbg_state)
  );

  // Clock
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  int n_cmp = 0;
  int n_mis = 0;

  // mem32 stand-in and bus monitor state
  logic [31:0] tb_mem [4];
  int          resp_at;      // RD cycle in which mem_valid is raised; 0 = never
  logic        ovr_en;
  logic [31:0] ovr_data;
  int          rd_run;
  int          wr_pulses, rd_cycles, rd_add_bad, overlap;
  logic [3:0]  wr_add_seen, exp_add;
  logic [31:0] wr_data_seen;

  // Reference model state
  logic [31:0] ref_mem [4];
  int          err_model;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: advance past the edge, monitor the bus, drive the memory side.
  task automatic tick();
    @(posedge Clk);
    #1;
    if (mem_rd) rd_run++; else rd_run = 0;
    if (mem_wr) begin
      wr_pulses++;
      wr_add_seen  = mem_add;
      wr_data_seen = mem_wdata;
      tb_mem[mem_add[3:2]] = mem_wdata;
    end
    if (mem_rd) begin
      rd_cycles++;
      if (mem_add !== exp_add) rd_add_bad++;
    end
    if (mem_wr && mem_rd) overlap++;
    if (mem_rd && resp_at != 0 && rd_run == resp_at) begin
      mem_valid = 1'b1;
      mem_rdata = ovr_en ? ovr_data : tb_mem[mem_add[3:2]];
    end else begin
      mem_valid = 1'b0;
      mem_rdata = $urandom;
    end
  endtask

  // Issue one command, collect its response, compare against the model.
  task automatic run_cmd(input logic we, input logic [3:0] addr, input logic [31:0] wdata,
                         input int hold);
    logic [31:0] e_data;
    logic [1:0]  e_code;
    int          e_lat, e_wr, e_rd, lat, n;
    logic [31:0] got_data;
    logic [1:0]  got_code;

    if (addr[1:0] != 2'b00) begin
      e_code = 2'b01; e_data = 32'd0; e_lat = 1; e_wr = 0; e_rd = 0;
    end else if (we) begin
      e_code = 2'b00; e_data = 32'd0; e_lat = 2; e_wr = 1; e_rd = 0;
      ref_mem[addr[3:2]] = wdata;
    end else if (resp_at >= 1 && resp_at <= TIMEOUT) begin
      e_code = 2'b00; e_data = ovr_en ? ovr_data : ref_mem[addr[3:2]];
      e_lat = resp_at + 1; e_wr = 0; e_rd = resp_at;
    end else begin
      e_code = 2'b10; e_data = 32'd0; e_lat = TIMEOUT + 1; e_wr = 0; e_rd = TIMEOUT;
    end
    if (e_code != 2'b00 && err_model < 255) err_model++;
    exp_add = addr;

    n = 0;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    chk("cmd_ready_before_accept", 32'(cmd_ready), 32'd1);

    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata;
    wr_pulses = 0; rd_cycles = 0; rd_add_bad = 0; overlap = 0;
    tick();
    cmd_valid = 1'b0; cmd_we = 1'($urandom); cmd_addr = 4'($urandom); cmd_wdata = $urandom;
    chk("cmd_ready_after_accept", 32'(cmd_ready), 32'd0);

    lat = 1;
    while (!rsp_valid && lat < 60) begin tick(); lat++; end
    chk("rsp_latency", 32'(lat), 32'(e_lat));
    chk("rsp_code", 32'(rsp_code), 32'(e_code));
    chk("rsp_rdata", rsp_rdata, e_data);
    chk("err_count", 32'(err_count), 32'(err_model));
    got_data = rsp_rdata;
    got_code = rsp_code;

    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_rdata", rsp_rdata, got_data);
      chk("hold_rsp_code", 32'(rsp_code), 32'(got_code));
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end

    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_valid_after_xfer", 32'(rsp_valid), 32'd0);
    chk("cmd_ready_after_xfer", 32'(cmd_ready), 32'd1);
    chk("wr_pulses", 32'(wr_pulses), 32'(e_wr));
    chk("rd_cycles", 32'(rd_cycles), 32'(e_rd));
    chk("rd_add_bad", 32'(rd_add_bad), 32'd0);
    chk("strobe_overlap", 32'(overlap), 32'd0);
    if (e_wr == 1) begin
      chk("wr_add", 32'(wr_add_seen), 32'(addr));
      chk("wr_data", wr_data_seen, wdata);
    end
  endtask

  initial begin
    int rv_count;
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 4'd0; cmd_wdata = 32'd0;
    rsp_ready = 1'b0; mem_valid = 1'b0; mem_rdata = 32'd0;
    resp_at = 2; ovr_en = 1'b0; ovr_data = 32'd0; rd_run = 0;
    wr_pulses = 0; rd_cycles = 0; rd_add_bad = 0; overlap = 0;
    wr_add_seen = 4'd0; wr_data_seen = 32'd0; exp_add = 4'd0; err_model = 0;
    for (int i = 0; i < 4; i++) begin tb_mem[i] = 32'd0; ref_mem[i] = 32'd0; end

    // Reset state
    repeat (3) tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_code", 32'(rsp_code), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_add", 32'(mem_add), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    chk("cmd_ready_before_first_edge", 32'(cmd_ready), 32'd0);
    tick();
    chk("cmd_ready_after_first_edge", 32'(cmd_ready), 32'd1);

    // Write then read back
    resp_at = 2;
    run_cmd(1'b1, 4'd0,  32'hDEADBEEF, 0);
    run_cmd(1'b1, 4'd4,  32'hCAFEBABE, 0);
    run_cmd(1'b1, 4'd12, 32'h12345678, 0);
    run_cmd(1'b0, 4'd0,  32'd0, 0);
    run_cmd(1'b0, 4'd4,  32'd0, 0);
    run_cmd(1'b0, 4'd12, 32'd0, 0);

    // Misaligned addresses
    run_cmd(1'b0, 4'd14, 32'd0, 0);
    run_cmd(1'b1, 4'd1,  32'h0BAD0BAD, 0);
    chk("misaligned_err_count", 32'(err_count), 32'd2);

    // Read timeout
    resp_at = 0;
    run_cmd(1'b0, 4'd8, 32'd0, 0);
    chk("timeout_err_count", 32'(err_count), 32'd3);

    // Response back-pressure
    resp_at = 2;
    run_cmd(1'b0, 4'd4, 32'd0, 5);

    // Timeout boundary: valid in the last allowed RD cycle
    resp_at = TIMEOUT; ovr_en = 1'b1; ovr_data = 32'h0000ABCD;
    run_cmd(1'b0, 4'd8, 32'd0, 0);
    chk("boundary_err_count", 32'(err_count), 32'd3);
    ovr_en = 1'b0;

    // Randomized commands
    for (int i = 0; i < 40; i++) begin
      resp_at = $urandom_range(1, TIMEOUT + 1);
      run_cmd(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
              $urandom_range(0, 3));
    end

    // err_count saturation
    for (int i = 0; i < 260; i++) begin
      run_cmd(1'($urandom_range(0, 1)),
              {2'($urandom_range(0, 3)), 2'($urandom_range(1, 3))}, $urandom, 0);
    end
    chk("err_count_saturated", 32'(err_count), 32'd255);

    // Reset in the second RD cycle
    resp_at = 0; exp_add = 4'd8;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 4'd8;
    tick();
    cmd_valid = 1'b0;
    chk("midrd_rd_cycle1", 32'(mem_rd), 32'd1);
    tick();
    chk("midrd_rd_cycle2", 32'(mem_rd), 32'd1);
    rst = 1'b1;
    tick();
    chk("midrd_mem_rd", 32'(mem_rd), 32'd0);
    chk("midrd_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrd_err_count", 32'(err_count), 32'd0);
    chk("midrd_cmd_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    err_model = 0;
    tick();
    chk("midrd_cmd_ready_release", 32'(cmd_ready), 32'd1);
    rv_count = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rsp_valid) rv_count++;
    end
    chk("midrd_no_response", 32'(rv_count), 32'd0);
    resp_at = 2;
    run_cmd(1'b0, 4'd0, 32'd0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mem32_master.md
# mem32_master

Command-side initiator for the `mem32` 16-entry word store. Accepts one read or write command at a time from a host over a valid/ready handshake and drives the `mem32` strobe, address and data pins. For reads, it captures `Data_out_32` when the memory's `valid` rises. It returns exactly one response per command, with a status code that covers misaligned addresses and reads that never complete.

## Interface

- `TIMEOUT`, default 8: maximum number of cycles spent in RD waiting for `mem_valid` before a timeout response is returned; legal range 2–255.
- `Clk`  in  1  rising-edge clock for all state.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  host command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_we`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  4  byte address; word-aligned values are 0, 4, 8 and 12.
- `cmd_wdata`  in  32  write data.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  host accepts the response.
- `rsp_rdata`  out  32  read data; 0 for writes and errors.
- `rsp_code`  out  2  00 = OK, 01 = misaligned, 10 = timeout, 11 = reserved (never driven).
- `err_count`  out  8  saturating count of non-OK responses.
- `mem_wr`  out  1  to `mem32` `wr`.
- `mem_rd`  out  1  to `mem32` `rd`.
- `mem_add`  out  4  to `mem32` `in_add`.
- `mem_wdata`  out  32  to `mem32` `Data_in_32`.
- `mem_rdata`  in  32  from `mem32` `Data_out_32`.
- `mem_valid`  in  1  from `mem32` `valid`.

## Operation

- **Register boundary:** all outputs are driven from registers; there are no combinational input-to-output paths.
- **States:** IDLE, WR, RD, RESP.
- **IDLE:**
  - `cmd_ready`=1.
  - When `cmd_valid`=1, the block latches `cmd_we`, `cmd_addr` and `cmd_wdata`.
  - If `cmd_addr[1:0]` is not 00: go to RESP with code 01 and `rsp_rdata`=0; `mem_wr` and `mem_rd` are never asserted for this command.
  - Else if `cmd_we`=1: go to WR.
  - Else: go to RD with the wait counter cleared.
- **WR:**
  - `mem_wr`=1 for exactly one cycle; `mem_add` and `mem_wdata` carry the latched values.
  - Next state is RESP with code 00 and `rsp_rdata`=0.
- **RD:**
  - `mem_rd`=1 and `mem_add` holds the latched address throughout.
  - `mem_valid` is sampled on every edge spent in RD, including the first.
  - If `mem_valid`=1: capture `mem_rdata` into `rsp_rdata`, code 00, go to RESP.
  - Otherwise the wait counter increments. When the counter reaches `TIMEOUT`-1 with `mem_valid` still 0, go to RESP with code 10 and `rsp_rdata`=0.
  - Wait counter width is ceil(log2(TIMEOUT))+1 bits.
- **RESP:**
  - `rsp_valid`=1; `rsp_rdata` and `rsp_code` are held stable until `rsp_ready`=1 is sampled.
  - On that edge the block goes to IDLE.
- **Strobe rules:**
  - `mem_wr` and `mem_rd` are never 1 in the same cycle.
  - Both are 0 in IDLE and RESP.
- **Idle bus values:** `mem_add` and `mem_wdata` hold their last values when not strobed; they are 0 after reset.
- **err_count:** increments by 1 on the edge RESP is entered with a non-OK code, and saturates at 255.
- **Reset:**
  - `rst`=1 at any edge returns the block to IDLE, discards any in-flight command or pending response, and clears the wait counter and `err_count`.
  - Reset values are 0 for every output: `cmd_ready`, `rsp_valid`, `rsp_rdata`, `rsp_code`, `err_count`, `mem_wr`, `mem_rd`, `mem_add`, `mem_wdata`.
  - `cmd_ready` becomes 1 one cycle after the first edge with `rst`=0.

## Timing

- **Handshake rule:** a command transfers on an edge with `cmd_valid` & `cmd_ready`; a response transfers on an edge with `rsp_valid` & `rsp_ready`.
- **Write latency:**
  - Edge 0: command accepted.
  - Cycle 1: `mem_wr`=1.
  - Cycle 2: `rsp_valid`=1.
  - Minimum 3 cycles per write with `rsp_ready` held high.
- **Read latency:**
  - With `mem_valid` first high in RD cycle k (k ≥ 1), `rsp_valid` rises in cycle k+1.
  - With `mem32` responding one cycle after `rd`: `mem_rd` is high for 2 cycles and `rsp_valid` is high 3 cycles after acceptance.
- **Misaligned:** `rsp_valid` is high 1 cycle after acceptance.
- **Timeout:** `mem_rd` is high for exactly `TIMEOUT` cycles; `rsp_valid` rises in the cycle after the last one.
- **Back-pressure:** `cmd_ready`=0 from the cycle after acceptance until the cycle after the response transfers; one command is outstanding at most.
- **Simultaneous events:** a `mem_valid` sampled on the same edge the counter hits `TIMEOUT`-1 wins and produces code 00.

## Test plan

- **Write then read back:**
  - Stimulus: writes DEADBEEF→0, CAFEBABE→4, 12345678→12, then reads of 0, 4 and 12.
  - Required: write responses have code 00; each write shows exactly one `mem_wr` pulse at the correct `mem_add`; reads return DEADBEEF, CAFEBABE and 12345678, each with code 00.
- **Misaligned address:**
  - Stimulus: read addr 14 (1110), then write addr 1.
  - Required: code 01 with `rsp_rdata`=0; `mem_rd` and `mem_wr` stay 0 throughout; `err_count`=2.
- **Read timeout:**
  - Stimulus: read addr 8 with `mem_valid` tied 0, `TIMEOUT`=8.
  - Required: `mem_rd` high for exactly 8 cycles; response code 10 with `rsp_rdata`=0; `err_count` increments by 1.
- **Response back-pressure:**
  - Stimulus: `rsp_ready`=0 for 5 cycles after a read of addr 4.
  - Required: `rsp_valid`, `rsp_rdata`=CAFEBABE and code 00 are held stable for all 5 cycles; `cmd_ready`=0 throughout; the next command is accepted in the cycle after the transfer.
- **Reset mid-read:**
  - Stimulus: `rst`=1 in the second RD cycle.
  - Required: on the next edge `mem_rd`=0, `rsp_valid`=0 and `err_count`=0; no response is ever issued for that command; `cmd_ready`=1 one cycle after `rst` falls.
- **Timeout boundary:**
  - Stimulus: `mem_valid` pulse (data 0000ABCD) arriving in RD cycle 8 with `TIMEOUT`=8.
  - Required: code 00 with `rsp_rdata`=0000ABCD; `err_count` unchanged.
